tile_map_ctrl: RTL

- Owns the on-screen tile map: one 4-bit entry per 32x32 tile, 32 columns x 24 rows, covering 1024x768.
- Drives BLOCK_GEN's texture_number and inversion for every pixel.
- Arbitrates map updates from two game-logic requesters (A: player logic, B: bomb logic).
- Runs a self-clearing sequence after reset and on command, and generates the per-frame flash phase for blinking tiles.

---
 rtl/tile_map_pkg.sv | 37 +++
 rtl/tile_map_arbiter.sv | 48 ++++
 rtl/tile_map_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_pkg.sv
// -----------------------------------------------------------------------------
// tile_map_pkg
// Shared types and constants for the tile map controller.
//   tile_entry_t : one map entry {flash, tex[2:0]}
//   tile_state_e : controller FSM states (IDLE, CLEAR)
//   ST_IDLE/ST_CLEAR : the same state codes as plain constants, so the state
//                      register can stay a plain logic vector
//   TEX_EMPTY / TEX_WALL : texture indices written by the clear sequence
//   MAP_AW : map address width, address = {row[4:0], col[4:0]}
// -----------------------------------------------------------------------------
package tile_map_pkg;

    localparam int MAP_AW  = 10;
    localparam int COORD_W = 5;

    localparam logic [2:0] TEX_EMPTY = 3'd0;
    localparam logic [2:0] TEX_WALL  = 3'd1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } tile_state_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef struct packed {
        logic       flash;
        logic [2:0] tex;
    } tile_entry_t;

    function automatic logic [MAP_AW-1:0] map_addr(input logic [COORD_W-1:0] row,
                                                   input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/tile_map_arbiter.sv
// -----------------------------------------------------------------------------
// tile_map_arbiter
// Two-way round-robin arbiter for map write requests.
//   clk, rst     : clock, asynchronous active-low reset
//   en           : arbitration allowed this cycle (controller idle, no clear)
//   req_a, req_b : pending write requests
//   win_a, win_b : combinational winner of this cycle (drives the map write)
//   gnt_a, gnt_b : registered one-cycle grants, high the cycle after winning
// On a tie the requester not granted last time wins; after reset B counts as
// last granted, so A wins the first tie.
// -----------------------------------------------------------------------------
module tile_map_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic win_a,
    output logic win_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b;

    always_comb begin
        win_a = en & req_a & (~req_b | last_b);
        win_b = en & req_b & (~req_a | ~last_b);
    end

    // ---- grant register stage ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            last_b <= 1'b1;
        end else begin
            gnt_a <= win_a;
            gnt_b <= win_b;
            if (win_a) begin
                last_b <= 1'b0;
            end else if (win_b) begin
                last_b <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_map_ctrl.sv
// -----------------------------------------------------------------------------
// tile_map_ctrl
// Owns the on-screen tile map (one 4-bit entry per tile), looks up the entry
// under the current pixel for BLOCK_GEN, arbitrates map writes from two
// game-logic requesters, clears the map after reset or on command, and
// produces the blink phase for flashing tiles.
//
// Ports:
//   clk, rst              : pixel clock, asynchronous active-low reset
//   hcount, vcount        : current pixel position
//   vsync                 : frame sync, active high
//   texture_number        : texture index for the pixel (1 clk after hcount/vcount;
//   inversion               the surrounding top delays BLOCK_GEN timing to match)
//   req_x/col_x/row_x/data_x : requester x write (x = a: player, b: bomb)
//   gnt_x                 : one-cycle grant, map written on the same edge
//   clr_req               : start a full-map clear (sampled only when idle)
//   busy                  : high while clearing
//
// Build option: define TILE_MAP_BORDER_LOCK_EN to make the outer ring of tiles
// indestructible walls (cleared to TEX_WALL, requester writes discarded).
// -----------------------------------------------------------------------------
module tile_map_ctrl
    import tile_map_pkg::*;
#(
    parameter int MAP_W        = 32,
    parameter int MAP_H        = 24,
    parameter int TILE_LOG2    = 5,
    parameter int FLASH_FRAMES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        hcount,
    input  logic [10:0]        vcount,
    input  logic               vsync,
    output logic [2:0]         texture_number,
    output logic               inversion,
    input  logic               req_a,
    input  logic [COORD_W-1:0] col_a,
    input  logic [COORD_W-1:0] row_a,
    input  logic [3:0]         data_a,
    output logic               gnt_a,
    input  logic               req_b,
    input  logic [COORD_W-1:0] col_b,
    input  logic [COORD_W-1:0] row_b,
    input  logic [3:0]         data_b,
    output logic               gnt_b,
    input  logic               clr_req,
    output logic               busy
);

    localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    tile_entry_t map_mem [0:(1<<MAP_AW)-1];

    logic [0:0]         state;
    logic [COORD_W-1:0] clr_row, clr_col;
    logic               win_a, win_b;
    logic               wr_en;
    logic [MAP_AW-1:0]  wr_addr;
    tile_entry_t        wr_data;
    logic               vsync_q, flash_phase;
    logic [FC_W-1:0]    frame_cnt;

    function automatic logic in_bounds(input logic [COORD_W-1:0] r,
                                       input logic [COORD_W-1:0] c);
        return ({1'b0, r} < 6'(MAP_H)) && ({1'b0, c} < 6'(MAP_W));
    endfunction

`ifdef TILE_MAP_BORDER_LOCK_EN
    function automatic logic is_border(input logic [COORD_W-1:0] r,
                                       input logic [COORD_W-1:0] c);
        return (r == '0) || (r == COORD_W'(MAP_H-1)) ||
               (c == '0) || (c == COORD_W'(MAP_W-1));
    endfunction
`endif

    // Off-map rows (row >= MAP_H) still get a grant but never touch the map.
    function automatic logic writable(input logic [COORD_W-1:0] r,
                                      input logic [COORD_W-1:0] c);
`ifdef TILE_MAP_BORDER_LOCK_EN
        return in_bounds(r, c) && !is_border(r, c);
`else
        return in_bounds(r, c);
`endif
    endfunction

    tile_map_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == ST_IDLE) && !clr_req),
        .req_a (req_a),
        .req_b (req_b),
        .win_a (win_a),
        .win_b (win_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // ---- write select: clear sequence has priority, then the arbiter winner ----
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = map_addr(clr_row, clr_col);
        wr_data = '{flash: 1'b0, tex: TEX_EMPTY};
        if (state == ST_CLEAR) begin
            wr_en = 1'b1;
`ifdef TILE_MAP_BORDER_LOCK_EN
            if (is_border(clr_row, clr_col)) begin
                wr_data.tex = TEX_WALL;
            end
`endif
        end else if (win_a) begin
            wr_en   = writable(row_a, col_a);
            wr_addr = map_addr(row_a, col_a);
            wr_data = tile_entry_t'(data_a);
        end else if (win_b) begin
            wr_en   = writable(row_b, col_b);
            wr_addr = map_addr(row_b, col_b);
            wr_data = tile_entry_t'(data_b);
        end
    end

    // ---- map storage (not reset; the clear sequence initialises it) ----
    always_ff @(posedge clk) begin
        if (wr_en) begin
            map_mem[wr_addr] <= wr_data;
        end
    end

    // ---- FSM and clear pointer ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            clr_row <= '0;
            clr_col <= '0;
        end else if (state == ST_IDLE) begin
            if (clr_req) begin
                state   <= ST_CLEAR;
                busy    <= 1'b1;
                clr_row <= '0;
                clr_col <= '0;
            end
        end else begin
            if (clr_col == COORD_W'(MAP_W-1)) begin
                clr_col <= '0;
                if (clr_row == COORD_W'(MAP_H-1)) begin
                    clr_row <= '0;
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                end else begin
                    clr_row <= clr_row + 1'b1;
                end
            end else begin
                clr_col <= clr_col + 1'b1;
            end
        end
    end

    // ---- flash phase: counts vsync rising edges, independent of clearing ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q     <= 1'b0;
            frame_cnt   <= '0;
            flash_phase <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q) begin
                if (frame_cnt == FC_W'(FLASH_FRAMES-1)) begin
                    frame_cnt   <= '0;
                    flash_phase <= ~flash_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // ---- pixel lookup stage p0: tile coordinates and map read ----
    logic [10:0] px_col_p0, px_row_p0;
    logic        in_map_p0;
    tile_entry_t rd_entry_p0;

    always_comb begin
        px_col_p0   = hcount >> TILE_LOG2;
        px_row_p0   = vcount >> TILE_LOG2;
        in_map_p0   = (px_col_p0 < 11'(MAP_W)) && (px_row_p0 < 11'(MAP_H));
        rd_entry_p0 = map_mem[map_addr(px_row_p0[COORD_W-1:0], px_col_p0[COORD_W-1:0])];
    end

    // ---- pixel output stage p1: registered texture and inversion ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            texture_number <= TEX_EMPTY;
            inversion      <= 1'b0;
        end else if ((state == ST_CLEAR) || !in_map_p0) begin
            texture_number <= TEX_EMPTY;
            inversion      <= 1'b0;
        end else begin
            texture_number <= rd_entry_p0.tex;
            inversion      <= rd_entry_p0.flash & flash_phase;
        end
    end

endmodule
